// File: rtl/game_display_sequencer.sv
// Reaction-game flow controller: sequences idle/blue/green/win/lose
// rounds in video frames and drives the VGA colour-select controls.
module game_display_sequencer #(
    parameter int ROUNDS_TO_WIN   = 5,
    parameter int GREEN_FRAMES    = 45,
    parameter int BLUE_MIN_FRAMES = 30,
    parameter int BLUE_RAND_BITS  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startBtn,
    input  logic       playerBtn,
    input  logic       frameTick,
    output logic       startSignal,
    output logic       inBlueRound,
    output logic       inGreenRound,
    output logic       winSignal,
    output logic       loseSignal,
    output logic [3:0] roundCount
);

    typedef enum logic [2:0] {
        IDLE,
        BLUE,
        GREEN,
        WIN,
        LOSE
    } state_t;

    localparam logic [3:0]  WIN_COUNT  = 4'(ROUNDS_TO_WIN);
    localparam logic [11:0] GREEN_LAST = 12'(GREEN_FRAMES - 1);
    localparam logic [11:0] BLUE_BASE  = 12'(BLUE_MIN_FRAMES);
    localparam logic [11:0] RAND_MASK  = 12'((1 << BLUE_RAND_BITS) - 1);

    state_t      state;
    state_t      stateNext;
    logic        prevStart;
    logic        prevPlayer;
    logic        prevTick;
    logic        startRise;
    logic        playerRise;
    logic        tickRise;
    logic [15:0] lfsr;
    logic        lfsrFb;
    logic [11:0] frameCnt;
    logic [11:0] blueLen;
    logic [11:0] blueLenNew;
    logic        blueLast;
    logic        greenLast;
    logic        counting;
    logic [3:0]  roundNext;
    logic [3:0]  roundInc;

    assign startRise  = startBtn & ~prevStart;
    assign playerRise = playerBtn & ~prevPlayer;
    assign tickRise   = frameTick & ~prevTick;

    // Buttons preset high so a press held through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevStart  <= 1'b1;
            prevPlayer <= 1'b1;
            prevTick   <= 1'b0;
        end else begin
            prevStart  <= startBtn;
            prevPlayer <= playerBtn;
            prevTick   <= frameTick;
        end
    end

    assign lfsrFb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsrFb};
        end
    end

    assign blueLenNew = BLUE_BASE + (lfsr[11:0] & RAND_MASK);
    assign blueLast   = tickRise && (frameCnt == blueLen - 12'd1);
    assign greenLast  = tickRise && (frameCnt == GREEN_LAST);
    assign roundInc   = roundCount + 4'd1;
    assign counting   = (state == BLUE) || (state == GREEN);

    always_comb begin
        stateNext = state;
        roundNext = roundCount;
        unique case (state)
            IDLE: begin
                if (startRise) begin
                    stateNext = BLUE;
                    roundNext = 4'd0;
                end
            end
            BLUE: begin
                if (startRise) begin
                    stateNext = IDLE;
                end else if (playerRise) begin
                    stateNext = LOSE;
                end else if (blueLast) begin
                    stateNext = GREEN;
                end
            end
            GREEN: begin
                if (startRise) begin
                    stateNext = IDLE;
                end else if (playerRise) begin
                    roundNext = roundInc;
                    if (roundInc == WIN_COUNT) begin
                        stateNext = WIN;
                    end else begin
                        stateNext = BLUE;
                    end
                end else if (greenLast) begin
                    stateNext = LOSE;
                end
            end
            WIN, LOSE: begin
                if (startRise) begin
                    stateNext = BLUE;
                    roundNext = 4'd0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            roundCount <= 4'd0;
            frameCnt   <= 12'd0;
            blueLen    <= 12'd0;
        end else begin
            state      <= stateNext;
            roundCount <= roundNext;
            // Every transition goes to a different state, so a change marks entry.
            if (stateNext != state) begin
                frameCnt <= 12'd0;
            end else if (tickRise && counting) begin
                frameCnt <= frameCnt + 12'd1;
            end
            if ((stateNext == BLUE) && (state != BLUE)) begin
                blueLen <= blueLenNew;
            end
        end
    end

    // Decoded from the next state so controls change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            startSignal  <= 1'b0;
            inBlueRound  <= 1'b0;
            inGreenRound <= 1'b0;
            winSignal    <= 1'b0;
            loseSignal   <= 1'b0;
        end else begin
            startSignal  <= stateNext != IDLE;
            inBlueRound  <= stateNext == BLUE;
            inGreenRound <= stateNext == GREEN;
            winSignal    <= stateNext == WIN;
            loseSignal   <= stateNext == LOSE;
        end
    end

endmodule

// File: tb/tb_game_display_sequencer.sv
// Bench for game_display_sequencer: directed game scenarios followed by
// random button/frame stimulus, all checked against an event-level model.
module tb_game_display_sequencer;

    localparam int ROUNDS = 2;
    localparam int GFR    = 3;
    localparam int BMIN   = 2;
    localparam int BBITS  = 2;

    localparam int P_IDLE  = 0;
    localparam int P_BLUE  = 1;
    localparam int P_GREEN = 2;
    localparam int P_WIN   = 3;
    localparam int P_LOSE  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       startBtn = 1'b1;
    logic       playerBtn = 1'b0;
    logic       frameTick = 1'b0;
    logic       startSignal;
    logic       inBlueRound;
    logic       inGreenRound;
    logic       winSignal;
    logic       loseSignal;
    logic [3:0] roundCount;

    int nCompared = 0;
    int nMismatched = 0;

    game_display_sequencer #(
        .ROUNDS_TO_WIN  (ROUNDS),
        .GREEN_FRAMES   (GFR),
        .BLUE_MIN_FRAMES(BMIN),
        .BLUE_RAND_BITS (BBITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .startBtn    (startBtn),
        .playerBtn   (playerBtn),
        .frameTick   (frameTick),
        .startSignal (startSignal),
        .inBlueRound (inBlueRound),
        .inGreenRound(inGreenRound),
        .winSignal   (winSignal),
        .loseSignal  (loseSignal),
        .roundCount  (roundCount)
    );

    always #5 clk = ~clk;

    // Reference model: game phase, ticks seen this round, presses this game.
    int          mPhase;
    int          mTicks;
    int          mBlueLen;
    int          mRounds;
    logic [15:0] mLfsr;
    logic        mPs;
    logic        mPp;
    logic        mPt;
    logic        sr;
    logic        pr;
    logic        tr;

    function automatic logic [15:0] lfsrNext(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPhase   = P_IDLE;
            mTicks   = 0;
            mBlueLen = 0;
            mRounds  = 0;
            mLfsr    = 16'hACE1;
            mPs      = 1'b1;
            mPp      = 1'b1;
            mPt      = 1'b0;
        end else begin
            sr  = startBtn & ~mPs;
            pr  = playerBtn & ~mPp;
            tr  = frameTick & ~mPt;
            mPs = startBtn;
            mPp = playerBtn;
            mPt = frameTick;
            case (mPhase)
                P_BLUE: begin
                    if (sr) begin
                        mPhase = P_IDLE;
                    end else if (pr) begin
                        mPhase = P_LOSE;
                    end else if (tr) begin
                        mTicks++;
                        if (mTicks == mBlueLen) begin
                            mPhase = P_GREEN;
                            mTicks = 0;
                        end
                    end
                end
                P_GREEN: begin
                    if (sr) begin
                        mPhase = P_IDLE;
                    end else if (pr) begin
                        mRounds++;
                        if (mRounds == ROUNDS) begin
                            mPhase = P_WIN;
                        end else begin
                            mPhase   = P_BLUE;
                            mTicks   = 0;
                            mBlueLen = BMIN + int'(mLfsr) % (1 << BBITS);
                        end
                    end else if (tr) begin
                        mTicks++;
                        if (mTicks == GFR) mPhase = P_LOSE;
                    end
                end
                default: begin
                    if (sr) begin
                        mPhase   = P_BLUE;
                        mTicks   = 0;
                        mRounds  = 0;
                        mBlueLen = BMIN + int'(mLfsr) % (1 << BBITS);
                    end
                end
            endcase
            mLfsr = lfsrNext(mLfsr);
        end
    end

    function automatic int expOut();
        return {27'd0, mPhase != P_IDLE, mPhase == P_BLUE,
                mPhase == P_GREEN, mPhase == P_WIN, mPhase == P_LOSE};
    endfunction

    function automatic int dutOut();
        return {27'd0, startSignal, inBlueRound, inGreenRound,
                winSignal, loseSignal};
    endfunction

    task automatic checkEq(input string tag, input int got, input int exp);
        nCompared++;
        if (got != exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        checkEq("ctrl", dutOut(), expOut());
        checkEq("rounds", int'(roundCount), mRounds);
    endtask

    task automatic tickPulse();
        frameTick = 1'b1;
        repeat (4) step();
        frameTick = 1'b0;
        repeat (4) step();
    endtask

    task automatic toGreen();
        int n;
        int len;
        n = 0;
        len = mBlueLen;
        while (!inGreenRound && n < 12) begin
            tickPulse();
            n++;
        end
        checkEq("reachGreen", int'(inGreenRound), 1);
        checkEq("bluePulses", n, len);
    endtask

    task automatic newGame();
        startBtn = 1'b0;
        step();
        startBtn = 1'b1;
        step();
        checkEq("newBlue", int'(inBlueRound), 1);
        checkEq("newRounds", int'(roundCount), 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        checkEq("heldStart", int'(startSignal), 0);

        newGame();
        checkEq("startSig", int'(startSignal), 1);

        toGreen();
        playerBtn = 1'b1;
        step();
        checkEq("hit1", int'(roundCount), 1);
        playerBtn = 1'b0;
        step();
        toGreen();
        playerBtn = 1'b1;
        step();
        checkEq("win", int'(winSignal), 1);
        checkEq("hit2", int'(roundCount), 2);
        playerBtn = 1'b0;
        step();

        newGame();
        playerBtn = 1'b1;
        step();
        checkEq("early", int'(loseSignal), 1);
        playerBtn = 1'b0;
        step();
        playerBtn = 1'b1;
        step();
        checkEq("loseHold", dutOut(), 5'b10001);
        playerBtn = 1'b0;
        step();

        newGame();
        toGreen();
        repeat (GFR) tickPulse();
        checkEq("timeout", int'(loseSignal), 1);

        newGame();
        toGreen();
        repeat (GFR - 1) tickPulse();
        frameTick = 1'b1;
        playerBtn = 1'b1;
        step();
        checkEq("lastHit", dutOut(), 5'b11000);
        checkEq("lastHitCnt", int'(roundCount), 1);
        playerBtn = 1'b0;
        repeat (3) step();
        frameTick = 1'b0;
        repeat (4) step();

        toGreen();
        startBtn = 1'b0;
        step();
        startBtn = 1'b1;
        playerBtn = 1'b1;
        step();
        checkEq("abort", dutOut(), 0);
        playerBtn = 1'b0;
        step();

        newGame();
        toGreen();
        tickPulse();
        #2 reset = 1'b1;
        #1;
        checkEq("asyncRst", dutOut(), 0);
        checkEq("asyncRstCnt", int'(roundCount), 0);
        step();
        reset = 1'b0;
        step();

        for (int c = 0; c < 4000; c++) begin
            frameTick = (c % 8) < 4;
            if ($urandom_range(0, 19) == 0) playerBtn = ~playerBtn;
            if ($urandom_range(0, 149) == 0) startBtn = ~startBtn;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule
